// File: rtl/mer_measure_ctrl.sv
// mer_measure_ctrl: window-based MER measurement sequencer.
// Sums per-symbol reference power and squared error over 2^LOG2_WINDOW symbols.
// It then presents the window averages to the MER lookup table, waits for the
// table's index pipeline to settle, and pulses the table enable once.
// The table result is captured and published with a one-cycle valid strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | LUT held in reset, accumulators clear, waiting for start/continuous
// ACCUM   | summing samples on clk_en until the window is full
// LOAD    | window averages driven to the LUT inputs, accumulators cleared
// WAIT    | LUT inputs held while its index pipeline settles
// FIRE    | single-cycle LUT enable
// CAPTURE | LUT result latched into mer, valid strobe, restart or go idle

module mer_measure_ctrl #(
  parameter int LOG2_WINDOW = 10,
  parameter int LUT_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               continuous,
  input  logic signed [17:0] mapper_sq,
  input  logic signed [17:0] error_sq,
  output logic signed [17:0] lut_mapper_power,
  output logic signed [17:0] lut_error_power,
  output logic               lut_clk_en,
  output logic               lut_reset,
  input  logic signed [6:0]  lut_mer,
  output logic signed [6:0]  mer,
  output logic               mer_valid,
  output logic               mer_error,
  output logic               busy
);

  localparam int AW = 18 + LOG2_WINDOW;
  // The latency down-counter starts at LUT_LATENCY-1 and fires on terminal count 0.
  localparam int LW = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
  localparam logic [LW-1:0]          LAT_LOAD = LW'(LUT_LATENCY - 1);
  localparam logic [LW-1:0]          LAT_ONE  = 1;
  localparam logic [LOG2_WINDOW-1:0] CNT_LAST = '1;
  localparam logic [LOG2_WINDOW-1:0] CNT_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_LOAD,
    S_WAIT,
    S_FIRE,
    S_CAPTURE
  } state_t;

  state_t                   state;
  logic signed [AW-1:0]     acc_m;
  logic signed [AW-1:0]     acc_e;
  logic [LOG2_WINDOW-1:0]   sample_cnt;
  logic [LW-1:0]            lat_cnt;
  logic signed [AW-1:0]     ext_m;
  logic signed [AW-1:0]     ext_e;

  // Sign-extend the incoming samples to accumulator width.
  always_comb begin
    ext_m = {{LOG2_WINDOW{mapper_sq[17]}}, mapper_sq};
    ext_e = {{LOG2_WINDOW{error_sq[17]}}, error_sq};
  end

  // Measurement sequencer with registered LUT and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      acc_m            <= '0;
      acc_e            <= '0;
      sample_cnt       <= '0;
      lat_cnt          <= '0;
      lut_mapper_power <= '0;
      lut_error_power  <= '0;
      lut_clk_en       <= 1'b0;
      lut_reset        <= 1'b1;
      mer              <= '0;
      mer_valid        <= 1'b0;
      mer_error        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      lut_clk_en <= 1'b0;
      mer_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          acc_m      <= '0;
          acc_e      <= '0;
          sample_cnt <= '0;
          if (start || continuous) begin
            state     <= S_ACCUM;
            busy      <= 1'b1;
            lut_reset <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (clk_en) begin
            acc_m      <= acc_m + ext_m;
            acc_e      <= acc_e + ext_e;
            sample_cnt <= sample_cnt + CNT_ONE;
            if (sample_cnt == CNT_LAST) state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Upper 18 bits of the sum are the arithmetic-shifted, truncated average.
          lut_mapper_power <= acc_m[AW-1:LOG2_WINDOW];
          lut_error_power  <= acc_e[AW-1:LOG2_WINDOW];
          acc_m            <= '0;
          acc_e            <= '0;
          sample_cnt       <= '0;
          lat_cnt          <= LAT_LOAD;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state      <= S_FIRE;
            lut_clk_en <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end
        end
        S_FIRE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          mer       <= lut_mer;
          mer_error <= (lut_mer == -7'sd1);
          mer_valid <= 1'b1;
          if (continuous) begin
            state <= S_ACCUM;
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            lut_reset <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          lut_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mer_measure_ctrl.md
# mer_measure_ctrl

Window-based MER measurement controller sitting between the demodulator's per-symbol power/error stream and the `mer_calc_lut` table.
- Accumulates per-symbol reference power and squared error over a window of 2^LOG2_WINDOW symbols.
- Forms window averages by arithmetic shift.
- Sequences the LUT (load, pipeline settle, enable, capture) and publishes the result with a one-cycle valid strobe.
- Supports single-shot and continuous measurement.

## Interface
Parameters:
- LOG2_WINDOW, 10, log2 of symbols per measurement window (range 1..14)
- LUT_LATENCY, 3, clocks the LUT inputs must be held stable before its enable is pulsed (covers its index pipeline)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- clk_en  in  1  symbol strobe; mapper_sq/error_sq valid when high
- start  in  1  level-sampled; begins one measurement when IDLE
- continuous  in  1  when high, a new window starts automatically after each result
- mapper_sq  in  18 signed  per-symbol reference power
- error_sq  in  18 signed  per-symbol squared error
- lut_mapper_power  out  18 signed  window-average reference power to LUT
- lut_error_power  out  18 signed  window-average error power to LUT
- lut_clk_en  out  1  LUT enable, single-cycle pulse
- lut_reset  out  1  LUT clear, active-high
- lut_mer  in  7 signed  LUT result
- mer  out  7 signed  last captured MER; held until next capture
- mer_valid  out  1  one-cycle pulse when mer updates
- mer_error  out  1  registered with mer; high when captured value is -1 (LUT out-of-range)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, LOAD, WAIT, FIRE, CAPTURE.
- IDLE:
  - lut_reset=1; accumulators and sample counter cleared.
  - start=1 or continuous=1 → ACCUM next cycle.
- ACCUM:
  - Each clk_en cycle adds sign-extended mapper_sq and error_sq into accumulators of 18+LOG2_WINDOW bits signed, and increments the counter.
  - Cycles with clk_en=0 are ignored.
  - When the sample accepted has counter = 2^LOG2_WINDOW-1 → LOAD.
- LOAD:
  - lut_mapper_power / lut_error_power ← accumulator >>> LOG2_WINDOW, keeping the low 18 bits. The arithmetic shift preserves sign; no rounding.
  - Accumulators and counter cleared. → WAIT.
- WAIT: latency counter runs LUT_LATENCY cycles with lut_clk_en=0 and LUT inputs held → FIRE.
- FIRE: lut_clk_en=1 for exactly this cycle → CAPTURE.
- CAPTURE:
  - mer ← lut_mer; mer_error ← (lut_mer == -7'sd1); mer_valid=1 on the following cycle only.
  - Next state: continuous=1 → ACCUM; else → IDLE.
- lut_reset=0 in all states except IDLE.
- Samples arriving in LOAD through CAPTURE are discarded. A new window starts with the first clk_en after re-entering ACCUM.
- start while busy: ignored; no queuing.
- continuous deasserted mid-window: the current window completes and its result is published, then IDLE.
- Range checking is left to the LUT. The controller only flags the -1 code.

## Timing
- Reset values:
  - state IDLE, all counters and accumulators 0.
  - lut_mapper_power=0, lut_error_power=0, lut_clk_en=0, lut_reset=1 (IDLE).
  - mer=0, mer_valid=0, mer_error=0, busy=0.
- Reset asserted mid-window or mid-sequence: immediate return to IDLE. The partial window is lost and mer keeps no stale pulse.
- Let edge E0 accept the last sample of a window:
  - E1 loads the LUT inputs.
  - lut_clk_en is high during the cycle after E(1+LUT_LATENCY).
  - mer/mer_valid become visible after E(3+LUT_LATENCY). With the default, that is 6 clocks after E0.
- IDLE→ACCUM: 1 cycle after start is sampled high. busy rises on the same edge.
- Minimum window duration is 2^LOG2_WINDOW clocks (clk_en tied high).
- lut_mapper_power/lut_error_power hold from LOAD until the next LOAD. They are never changed while lut_clk_en is high.

## Test plan
- LOG2_WINDOW=4, clk_en high, mapper_sq=2000, error_sq=20, start pulse; bench LUT model (3-cycle pipeline) returns 25 for (2000,20) → lut inputs 2000/20, single lut_clk_en, mer=25, mer_valid one cycle, 6 clocks after 16th sample, busy drops next cycle.
- Same, clk_en every 3rd cycle → result identical; 16 accepted samples counted, idle cycles ignored.
- Alternating error_sq 10/31 over 16 samples → lut_error_power=20 (truncation); mapper_sq=-8 constant → lut_mapper_power=-8 (sign kept).
- continuous=1 for three windows; LUT model returns -1 for second → three mer_valid pulses, mer_error high only with the second; samples during LOAD..CAPTURE not counted.
- start pulsed during ACCUM → ignored, exactly one result; continuous dropped mid-window → window finishes, then IDLE with lut_reset=1.
- reset low during WAIT → all outputs to reset values asynchronously, no mer_valid; after release, start gives a clean full-window result.
